uart_tx: RTL and testbench

UART transmitter that serialises one NB_BIT-bit word per request into a frame with the following layout:

- a start bit;
- NB_BIT data bits, LSB first;
- an optional even-parity bit;
- SB_TICK ticks of stop.

Timing comes from the shared baud-rate generator enable `s_tick`, with 16 ticks per bit. The block is the transmit half of the UART and its frame format matches `uart_rx`. It sits between the host-side data path, which issues `tx_start`/`din`, and the serial line.

---
 rtl/uart_tx.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// UART transmitter. Serialises one NB_BIT-bit word per request into a frame:
// start bit (low), NB_BIT data bits LSB first, an optional even-parity bit,
// then SB_TICK ticks of stop (high). Bit timing comes from the shared baud
// generator enable s_tick, 16 ticks per bit. The frame format matches uart_rx.
//
// Parameters:
//   NB_BIT    - data bits per frame
//   SB_TICK   - stop length in ticks (16, 24, 32 = 1, 1.5, 2 stop bits)
//   PARITY_EN - 1 inserts an even-parity bit after the data, 0 omits it
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   s_tick       in   one-cycle baud enable, 16 per bit period
//   tx_start     in   send request, only sampled in idle
//   din          in   NB_BIT word to send
//   tx           out  registered serial line, idles high
//   tx_busy      out  registered, high whenever not idle
//   tx_done_tick out  one-cycle pulse as the final stop tick is consumed
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int NB_BIT    = 8,
    parameter int SB_TICK   = 16,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_tick,
    input  logic              tx_start,
    input  logic [NB_BIT-1:0] din,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done_tick
);

    localparam int NW = (NB_BIT > 1) ? $clog2(NB_BIT) : 1;

    localparam logic [4:0]    S_LAST_BIT  = 5'd15;
    localparam logic [4:0]    S_LAST_STOP = 5'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(NB_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [4:0]        s_reg, s_next;
    logic [NW-1:0]     n_reg, n_next;
    logic [NB_BIT-1:0] b_reg, b_next;
    logic              p_reg, p_next;
    logic              tx_reg, tx_next;
    logic              busy_reg, busy_next;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            p_reg     <= 1'b0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            p_reg     <= p_next;
            tx_reg    <= tx_next;
            busy_reg  <= busy_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Apart from idle -> start, nothing advances
    // without an s_tick.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        p_next     = p_reg;

        case (state_reg)
            ST_IDLE: begin
                if (tx_start) begin
                    b_next     = din;
                    p_next     = ^din;
                    s_next     = '0;
                    state_next = ST_START;
                end
            end

            ST_START: begin
                if (s_tick) begin
                    if (s_reg == S_LAST_BIT) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = ST_DATA;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end

            ST_DATA: begin
                if (s_tick) begin
                    if (s_reg == S_LAST_BIT) begin
                        s_next = '0;
                        b_next = b_reg >> 1;
                        n_next = n_reg + NW'(1);
                        if (n_reg == N_LAST) begin
                            state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end

            ST_PARITY: begin
                if (s_tick) begin
                    if (s_reg == S_LAST_BIT) begin
                        s_next     = '0;
                        state_next = ST_STOP;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end

            ST_STOP: begin
                if (s_tick) begin
                    if (s_reg == S_LAST_STOP) begin
                        s_next     = '0;
                        state_next = ST_IDLE;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. The line level is decoded from the *next* state so
    // that the registered tx already shows the new bit on the same edge
    // the state changes (start bit visible one edge after tx_start).
    // ------------------------------------------------------------------
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            ST_IDLE:   tx_next = 1'b1;
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = b_next[0];
            ST_PARITY: tx_next = p_next;
            ST_STOP:   tx_next = 1'b1;
            default:   tx_next = 1'b1;
        endcase

        busy_next    = (state_next != ST_IDLE);
        tx_done_tick = (state_reg == ST_STOP) && s_tick && (s_reg == S_LAST_STOP);
    end

    assign tx      = tx_reg;
    assign tx_busy = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Three transmitters run side by side on one clock and one shared s_tick
// (one idle cycle in every eight):
//   inst0: defaults (parity on, 1 stop bit)   - directed words, mid-frame
//                                               tx_start, reset mid-frame
//   inst1: PARITY_EN = 0                       - directed words
//   inst2: SB_TICK = 32                        - 256 random words, tx_start
//                                               held high (back-to-back)
// Stimulus pushes {parity, word} into a per-instance queue; a monitor per
// instance rebuilds each frame from the tx line tick by tick and checks it
// against the popped entry when tx_done_tick fires.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    int   cyc    = 0;
    logic s_tick = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        s_tick = (cyc % 8 != 7);
    end

    logic       rst0   = 1'b1;
    logic       rst12  = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [7:0] din0   = 8'h00, din1 = 8'h00, din2 = 8'h00;
    logic       tx0, tx1, tx2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;

    logic [2:0] tx_v, busy_v, done_v, rst_v;
    assign tx_v   = {tx2, tx1, tx0};
    assign busy_v = {busy2, busy1, busy0};
    assign done_v = {done2, done1, done0};
    assign rst_v  = {rst12, rst12, rst0};

    uart_tx #(.NB_BIT(8), .SB_TICK(16), .PARITY_EN(1)) u_dut0 (
        .clk(clk), .reset(rst0), .s_tick(s_tick), .tx_start(start0), .din(din0),
        .tx(tx0), .tx_busy(busy0), .tx_done_tick(done0)
    );
    uart_tx #(.NB_BIT(8), .SB_TICK(16), .PARITY_EN(0)) u_dut1 (
        .clk(clk), .reset(rst12), .s_tick(s_tick), .tx_start(start1), .din(din1),
        .tx(tx1), .tx_busy(busy1), .tx_done_tick(done1)
    );
    uart_tx #(.NB_BIT(8), .SB_TICK(32), .PARITY_EN(1)) u_dut2 (
        .clk(clk), .reset(rst12), .s_tick(s_tick), .tx_start(start2), .din(din2),
        .tx(tx2), .tx_busy(busy2), .tx_done_tick(done2)
    );

    int total = 0;
    int bad   = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];

    bit sd0 = 1'b0, sd1 = 1'b0, sd2 = 1'b0;

    // frame length in ticks: 16*(1+8+PARITY_EN)+SB_TICK
    function automatic int len_of(input int idx);
        case (idx)
            0:       return 176;
            1:       return 160;
            default: return 192;
        endcase
    endfunction

    function automatic bit pen_of(input int idx);
        return (idx != 1);
    endfunction

    function automatic bit pop_exp(input int idx, output logic [8:0] v);
        v = '0;
        case (idx)
            0: if (q0.size() > 0) begin v = q0.pop_front(); return 1'b1; end
            1: if (q1.size() > 0) begin v = q1.pop_front(); return 1'b1; end
            default: if (q2.size() > 0) begin v = q2.pop_front(); return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic wait_busy(input int idx, input logic val);
        int c;
        c = 0;
        while (busy_v[idx] !== val) begin
            @(negedge clk);
            c++;
            if (c > 3000) begin
                total++;
                bad++;
                $display("FAIL inst%0d busy_wait: got busy=%b required %b", idx, busy_v[idx], val);
                return;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: samples at negedge. A tick seen high at a negedge is the one
    // consumed at the next posedge, so the tx value recorded with it is the
    // level of the slot that tick belongs to.
    // ------------------------------------------------------------------
    task automatic mon(input int idx);
        logic       in_frame;
        logic       prev_done;
        int         t;
        int         busy_bad;
        int         nerr;
        int         slot;
        logic       ln [0:255];
        logic [8:0] e;
        logic       eb;
        logic [7:0] got_w;
        logic       got_p;
        in_frame  = 1'b0;
        prev_done = 1'b0;
        t         = 0;
        busy_bad  = 0;
        forever begin
            @(negedge clk);
            if (rst_v[idx]) begin
                in_frame  = 1'b0;
                prev_done = 1'b0;
                t         = 0;
            end else begin
                if (prev_done) begin
                    check($sformatf("inst%0d idle_after_done(busy,tx)", idx),
                          int'({busy_v[idx], tx_v[idx]}), 1);
                    prev_done = 1'b0;
                end
                if (!in_frame && tx_v[idx] === 1'b0) begin
                    in_frame = 1'b1;
                    t        = 0;
                    busy_bad = 0;
                    for (int k = 0; k < 256; k++) ln[k] = 1'bx;
                end
                if (done_v[idx] === 1'b1 && !(in_frame && s_tick)) begin
                    total++;
                    bad++;
                    $display("FAIL inst%0d stray_done: got done=1 required 0 (in_frame=%0d)", idx, in_frame);
                end
                if (in_frame && s_tick) begin
                    if (t < 256) ln[t] = tx_v[idx];
                    if (busy_v[idx] !== 1'b1) busy_bad++;
                    t++;
                    if (done_v[idx] === 1'b1) begin
                        in_frame  = 1'b0;
                        prev_done = 1'b1;
                        if (!pop_exp(idx, e)) begin
                            total++;
                            bad++;
                            $display("FAIL inst%0d unexpected_done: got done after %0d ticks required none", idx, t);
                        end else begin
                            nerr = 0;
                            for (int k = 0; k < t && k < 256; k++) begin
                                slot = k / 16;
                                if (slot == 0)                       eb = 1'b0;
                                else if (slot <= 8)                  eb = e[slot-1];
                                else if (slot == 9 && pen_of(idx))   eb = e[8];
                                else                                 eb = 1'b1;
                                if (ln[k] !== eb) nerr++;
                            end
                            for (int k = 0; k < 8; k++) got_w[k] = ln[16*(k+1)+8];
                            got_p = ln[16*9+8];
                            check($sformatf("inst%0d frame_ticks", idx), t, len_of(idx));
                            check($sformatf("inst%0d slot_errors", idx), nerr, 0);
                            check($sformatf("inst%0d word", idx), int'(got_w), int'(e[7:0]));
                            if (pen_of(idx))
                                check($sformatf("inst%0d parity", idx), int'(got_p), int'(e[8]));
                            check($sformatf("inst%0d busy_low_ticks", idx), busy_bad, 0);
                            $display("inst%0d frame word=%02h exp=%02h par=%b ticks=%0d",
                                     idx, got_w, e[7:0], got_p, t);
                        end
                    end else if (t >= 256) begin
                        in_frame = 1'b0;
                        total++;
                        bad++;
                        $display("FAIL inst%0d frame_overrun: got %0d ticks required %0d", idx, t, len_of(idx));
                    end
                end
            end
        end
    endtask

    task automatic go0(input logic [7:0] w, input logic p, input bit push);
        wait_busy(0, 1'b0);
        @(posedge clk);
        #1;
        din0   = w;
        start0 = 1'b1;
        if (push) q0.push_back({p, w});
        @(posedge clk);
        #1;
        start0 = 1'b0;
        check("inst0 start_tx", int'(tx0), 0);
        check("inst0 start_busy", int'(busy0), 1);
    endtask

    task automatic go1(input logic [7:0] w);
        wait_busy(1, 1'b0);
        @(posedge clk);
        #1;
        din1   = w;
        start1 = 1'b1;
        q1.push_back({1'b0, w});
        @(posedge clk);
        #1;
        start1 = 1'b0;
        check("inst1 start_tx", int'(tx1), 0);
    endtask

    // ---------------- inst0: directed ----------------
    initial begin
        int c;
        repeat (2) @(posedge clk);
        #1;
        check("inst0 reset_tx", int'(tx0), 1);
        check("inst0 reset_busy", int'(busy0), 0);
        check("inst0 reset_done", int'(done0), 0);
        rst0 = 1'b0;

        go0(8'hA5, 1'b0, 1'b1); wait_busy(0, 1'b0);
        go0(8'h01, 1'b1, 1'b1); wait_busy(0, 1'b0);
        go0(8'h00, 1'b0, 1'b1); wait_busy(0, 1'b0);

        // new requests mid-frame must not disturb the frame in progress
        go0(8'h55, 1'b0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            repeat (30) @(posedge clk);
            #1;
            din0   = 8'hFF;
            start0 = 1'b1;
            @(posedge clk);
            #1;
            start0 = 1'b0;
        end
        wait_busy(0, 1'b0);
        repeat (4) @(negedge clk);
        check("inst0 no_extra_frame_busy", int'(busy0), 0);

        // reset during data bit 3 (0x35 has bit3 = 0, so the line is low there)
        go0(8'h35, 1'b0, 1'b0);
        c = 0;
        while (c < 72) begin
            @(posedge clk);
            if (s_tick) c++;
        end
        #1;
        check("inst0 pre_reset_tx_low", int'(tx0), 0);
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        check("inst0 midreset_tx", int'(tx0), 1);
        check("inst0 midreset_busy", int'(busy0), 0);
        check("inst0 midreset_done", int'(done0), 0);
        rst0 = 1'b0;

        go0(8'h7E, 1'b0, 1'b1); wait_busy(0, 1'b0);
        sd0 = 1'b1;
    end

    // ---------------- inst1: no parity ----------------
    initial begin
        wait (rst12 == 1'b0);
        go1(8'h3C); wait_busy(1, 1'b0);
        go1(8'h96); wait_busy(1, 1'b0);
        sd1 = 1'b1;
    end

    // ---------------- inst2: back-to-back random, 2 stop bits ----------------
    initial begin
        logic [7:0] w [256];
        for (int i = 0; i < 256; i++) w[i] = 8'($urandom_range(0, 255));
        wait (rst12 == 1'b0);
        @(posedge clk);
        #1;
        din2 = w[0];
        q2.push_back({^w[0], w[0]});
        start2 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wait_busy(2, 1'b1);
            if (i + 1 < 256) begin
                din2 = w[i+1];
                q2.push_back({^w[i+1], w[i+1]});
            end else begin
                start2 = 1'b0;
            end
            wait_busy(2, 1'b0);
        end
        sd2 = 1'b1;
    end

    // ---------------- control ----------------
    initial begin
        int c;
        fork
            mon(0);
            mon(1);
            mon(2);
        join_none
        repeat (3) @(posedge clk);
        #1;
        rst12 = 1'b0;
        c = 0;
        while (!(sd0 && sd1 && sd2) && c < 90000) begin
            @(posedge clk);
            c++;
        end
        if (!(sd0 && sd1 && sd2)) begin
            total++;
            bad++;
            $display("FAIL timeout: got done flags %b%b%b required 111", sd2, sd1, sd0);
        end
        repeat (4) @(negedge clk);
        check("queues_drained", q0.size() + q1.size() + q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
